// File: rtl/imem_responder.sv
// imem_responder: memory-side responder for a single-outstanding instruction-fetch
// handshake. A request is accepted only while idle. After a fixed LATENCY it returns
// one 32-bit word, with an error flag for misaligned or out-of-range addresses.
// A simple write port preloads the word array.
//
// Handshake: reqValid is sampled only in IDLE; an accepted request produces exactly
// one respValid pulse LATENCY cycles later. respData/respErr are meaningful only
// while respValid=1 and hold their value otherwise. reqValid outside IDLE is ignored.
//
// Optional build macro IMEM_RESP_JITTER_EN adds 0..3 cycles of LFSR-driven extra
// latency per request. Leave it undefined for fixed latency.
`timescale 1ns/1ps

module imem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic [ADDR_W-1:0] reqAddr,
    output logic              respValid,
    output logic [31:0]       respData,
    output logic              respErr,
    output logic              is_busy,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_RESP_JITTER_EN
    localparam int CNT_W = $clog2(LATENCY + 1) + 2;
`else
    localparam int CNT_W = $clog2(LATENCY + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              resp_valid_q;
    logic [31:0]       resp_data_q;
    logic              resp_err_q;
    logic [31:0]       mem_q [DEPTH];

    logic [CNT_W-1:0]  lat_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_bad_d;
    logic [31:0]       resp_data_d;

    // A word address is bad when it is not word aligned or falls past the array.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word_idx;
        word_idx = {2'b00, a[ADDR_W-1:2]};
        return (a[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH));
    endfunction

`ifdef IMEM_RESP_JITTER_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR (taps 8,6,5,4) that supplies 0..3 extra wait cycles per request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign lat_d = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
    assign lat_d = CNT_W'(LATENCY);
`endif

    // The word latched into the response registers comes from the incoming request on
    // the direct IDLE->RESP path, otherwise from the address captured at acceptance.
    assign rd_addr_d   = (state_q == S_IDLE) ? reqAddr : addr_q;
    assign rd_bad_d    = addr_bad(rd_addr_d);
    assign resp_data_d = rd_bad_d ? 32'd0 : mem_q[rd_addr_d[IDX_W+1:2]];

    // Preload port: aligned, in-range writes land in the array in any state; others drop.
    always_ff @(posedge clock) begin
        if (wen && !addr_bad(waddr)) begin
            mem_q[waddr[IDX_W+1:2]] <= wdata;
        end
    end

    // Request FSM: IDLE accepts, WAIT counts down, RESP drives the one-cycle pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (reqValid) begin
                        addr_q <= reqAddr;
                        if (lat_d == CNT_W'(1)) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= resp_data_d;
                            resp_err_q   <= rd_bad_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= lat_d - CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= resp_data_d;
                        resp_err_q   <= rd_bad_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign respErr   = resp_err_q;
    assign is_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a cycle-level reference model (per-request due times,
// word array, optional reference LFSR) checked against the DUT every cycle, plus
// directed sequences with hand-computed literal expectations.
`timescale 1ns/1ps

module tb_imem_responder;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
`ifdef IMEM_RESP_JITTER_EN
  localparam int LAT     = 1;
  localparam int EXP_LAT = -1;
`else
  localparam int LAT     = 2;
  localparam int EXP_LAT = LAT;
`endif

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              reqValid = 1'b0;
  logic [ADDR_W-1:0] reqAddr = '0;
  logic              respValid;
  logic [31:0]       respData;
  logic              respErr;
  logic              is_busy;
  logic              wen = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [31:0]       wdata = '0;

  always #5 clock = ~clock;

  imem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqAddr(reqAddr),
    .respValid(respValid), .respData(respData), .respErr(respErr), .is_busy(is_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          started = 0;
  int          e = 0;
  bit          pend = 0;
  int          due = 0;
  int          free_e = 0;
  int          busy_end = -1;
  logic [31:0] p_addr = '0;
  logic        m_valid = 0;
  logic [31:0] m_data = '0;
  logic        m_err = 0;
  logic        m_busy = 0;
  logic [31:0] exp_q[$];
`ifdef IMEM_RESP_JITTER_EN
  logic [7:0]  m_lfsr = 8'hA5;
`endif

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  always @(posedge clock) begin
    int lat;
    started = 1;
    e++;
    if (!reset) begin
      pend = 0; m_valid = 0; m_data = '0; m_err = 0;
      free_e = e + 1; busy_end = -1;
`ifdef IMEM_RESP_JITTER_EN
      m_lfsr = 8'hA5;
`endif
    end else begin
      m_valid = 0;
      if (!pend && e >= free_e && reqValid) begin
        lat = LAT;
`ifdef IMEM_RESP_JITTER_EN
        lat = LAT + int'(m_lfsr[1:0]);
`endif
        pend = 1; p_addr = reqAddr;
        due = e + lat - 1; free_e = e + lat + 1; busy_end = due;
        exp_q.push_back(p_addr);
      end
      if (pend && e == due) begin
        pend = 0; m_valid = 1;
        void'(exp_q.pop_front());
        if (bad_addr(p_addr)) begin m_data = '0; m_err = 1; end
        else begin m_data = m_mem[int'(p_addr >> 2)]; m_err = 0; end
      end
`ifdef IMEM_RESP_JITTER_EN
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    end
    if (!reset) exp_q.delete();
    m_busy = (e <= busy_end);
    if (wen && !bad_addr(waddr)) m_mem[int'(waddr >> 2)] = wdata;
  end

  // Compare process: outputs checked against the model every cycle.
  always @(negedge clock) begin
    if (started) begin
      chk("cyc_respValid", 32'(respValid), 32'(m_valid));
      chk("cyc_respData", respData, m_data);
      chk("cyc_respErr", 32'(respErr), 32'(m_err));
      chk("cyc_is_busy", 32'(is_busy), 32'(m_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock); wen = 1; waddr = a; wdata = d;
    @(negedge clock); wen = 0;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] exp_d,
                        input logic exp_e, input int exp_lat);
    int lat;
    bit got;
    @(negedge clock); reqValid = 1; reqAddr = addr;
    @(negedge clock); reqValid = 0;
    lat = 1; got = 0;
    while (!got && lat <= 20) begin
      chk("req_busy", 32'(is_busy), 32'd1);
      if (respValid) got = 1;
      else begin @(negedge clock); lat++; end
    end
    chk("req_resp_seen", 32'(got), 32'd1);
    if (got) begin
      if (exp_lat >= 0) chk("req_latency", 32'(lat), 32'(exp_lat));
      else begin
        checks++;
        if (lat < LAT || lat > LAT + 3) begin
          errors++;
          $display("FAIL req_latency_range actual=%0d required=%0d..%0d", lat, LAT, LAT + 3);
        end
      end
      chk("req_data", respData, exp_d);
      chk("req_err", 32'(respErr), 32'(exp_e));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int rt[$];
    logic [31:0] rd[$];
    int exp_t[3];
    logic [31:0] exp_dv[3];
    exp_t  = '{2, 5, 8};
    exp_dv = '{32'h0000_0013, 32'h1111_1111, 32'h2222_2222};

    reset = 0;
    repeat (3) @(negedge clock);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_respData", respData, 32'd0);
    chk("rst_respErr", 32'(respErr), 32'd0);
    chk("rst_is_busy", 32'(is_busy), 32'd0);
    reset = 1;

    // Preload, including two writes that must be dropped.
    wr(32'h0000_0000, 32'h0000_0013);
    wr(32'h0000_0004, 32'h1111_1111);
    wr(32'h0000_0008, 32'h2222_2222);
    wr(32'h0000_0010, 32'hCAFE_0010);
    wr(32'h0000_0020, 32'h1234_5678);
    wr(32'h0000_0006, 32'h0000_0BAD);
    wr(32'(DEPTH * 4), 32'h0000_BAD2);

    do_req(32'h0000_0000, 32'h0000_0013, 1'b0, EXP_LAT);
    do_req(32'h0000_0006, 32'h0000_0000, 1'b1, EXP_LAT);
    do_req(32'(DEPTH * 4), 32'h0000_0000, 1'b1, EXP_LAT);
    do_req(32'h0000_0000, 32'h0000_0013, 1'b0, EXP_LAT);
    do_req(32'h0000_0004, 32'h1111_1111, 1'b0, EXP_LAT);

`ifndef IMEM_RESP_JITTER_EN
    // reqValid held high; address advances every LAT+1 cycles.
    for (int i = 0; i < 3 * (LAT + 1) + LAT + 3; i++) begin
      @(negedge clock);
      if (respValid) begin rt.push_back(i); rd.push_back(respData); end
      reqValid = (i < 3 * (LAT + 1));
      reqAddr  = ((i / (LAT + 1)) < 3) ? 32'((i / (LAT + 1)) * 4) : 32'd0;
    end
    reqValid = 0;
    chk("hold_resp_count", 32'(rt.size()), 32'd3);
    for (int k = 0; k < 3 && k < rt.size(); k++) begin
      chk("hold_resp_time", 32'(rt[k]), 32'(exp_t[k]));
      chk("hold_resp_data", rd[k], exp_dv[k]);
    end

    // Reset during WAIT drops the pending request.
    @(negedge clock); reqValid = 1; reqAddr = 32'h0000_0010;
    @(negedge clock); reqValid = 0; reset = 0;
    @(negedge clock); reset = 1;
    chk("drop_is_busy", 32'(is_busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("drop_no_resp", 32'(respValid), 32'd0);
    end
    do_req(32'h0000_0010, 32'hCAFE_0010, 1'b0, EXP_LAT);

    // Write lands on the same edge as the RESP-entry read: old data returned.
    @(negedge clock); reqValid = 1; reqAddr = 32'h0000_0020;
    @(negedge clock); reqValid = 0; wen = 1; waddr = 32'h0000_0020; wdata = 32'hDEAD_BEEF;
    @(negedge clock); wen = 0;
    chk("wr_race_valid", 32'(respValid), 32'd1);
    chk("wr_race_old_data", respData, 32'h1234_5678);
    do_req(32'h0000_0020, 32'hDEAD_BEEF, 1'b0, EXP_LAT);
`else
    // Jittered latency: range checked here, exact LFSR timing checked by the model.
    for (int i = 0; i < 16; i++) begin
      do_req(32'(i * 4 % 12), (i % 3 == 0) ? 32'h0000_0013 :
             (i % 3 == 1) ? 32'h1111_1111 : 32'h2222_2222, 1'b0, EXP_LAT);
    end
`endif

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
